// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit.
//   - memory mode width and BYTE/HALFWORD/WORD encodings (decoder D_MEM_mode)
//   - lsu_state_t: FSM states of dmem_lsu
//   - mode_size(): access size in bytes for a memory mode
package dmem_lsu_pkg;

  localparam int unsigned MEMORY_MODE_WIDTH = 2;

  localparam logic [MEMORY_MODE_WIDTH-1:0] BYTE_MEMORY_MODE     = 2'd0;
  localparam logic [MEMORY_MODE_WIDTH-1:0] HALFWORD_MEMORY_MODE = 2'd1;
  localparam logic [MEMORY_MODE_WIDTH-1:0] WORD_MEMORY_MODE     = 2'd2;

  localparam int unsigned LSU_BE_WIDTH = 4;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE0,
    WAIT0,
    ISSUE1,
    WAIT1,
    DONE
  } lsu_state_t;

  // The unused mode encoding behaves as a word access.
  function automatic logic [2:0] mode_size(input logic [MEMORY_MODE_WIDTH-1:0] mode);
    unique case (mode)
      BYTE_MEMORY_MODE:     return 3'd1;
      HALFWORD_MEMORY_MODE: return 3'd2;
      default:              return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Word-wide valid/ready data-memory bus.
//   master (LSU): drives bus_req_valid/we/addr/wdata/be, receives ready and the response
//   slave (memory): accepts requests, returns bus_rsp_valid/bus_rsp_rdata one beat at a time
interface dmem_lsu_if
  import dmem_lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) ();

  logic                    bus_req_valid;
  logic                    bus_req_ready;
  logic                    bus_req_we;
  logic [ADDR_WIDTH-1:0]   bus_req_addr;
  logic [31:0]             bus_req_wdata;
  logic [LSU_BE_WIDTH-1:0] bus_req_be;
  logic                    bus_rsp_valid;
  logic [31:0]             bus_rsp_rdata;

  modport master (
    output bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata, bus_req_be,
    input  bus_req_ready, bus_rsp_valid, bus_rsp_rdata
  );

  modport slave (
    input  bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata, bus_req_be,
    output bus_req_ready, bus_rsp_valid, bus_rsp_rdata
  );

endinterface

// File: rtl/dmem_lsu_align.sv
// Combinational lane alignment for the load/store unit.
//   offset_i/mode_i/unsigned_i : captured access attributes
//   wdata_i                    : store data (rs2)
//   lo_i/hi_i                  : beat0/beat1 read words (hi_i = 0 when not split)
//   split_o                    : access spans two words
//   be0_o/be1_o, wdata0_o/wdata1_o : per-beat byte enables and lane-shifted store data
//   load_data_o                : extracted, sign/zero-extended load result
module lsu_align
  import dmem_lsu_pkg::*;
#(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic [1:0]                   offset_i,
  input  logic [MEMORY_MODE_WIDTH-1:0] mode_i,
  input  logic                         unsigned_i,
  input  logic [31:0]                  wdata_i,
  input  logic [31:0]                  lo_i,
  input  logic [31:0]                  hi_i,
  output logic                         split_o,
  output logic [LSU_BE_WIDTH-1:0]      be0_o,
  output logic [LSU_BE_WIDTH-1:0]      be1_o,
  output logic [31:0]                  wdata0_o,
  output logic [31:0]                  wdata1_o,
  output logic [31:0]                  load_data_o
);

  logic [2:0]  size;
  logic [3:0]  span;
  logic [7:0]  mask;
  logic [63:0] w64;
  logic [63:0] r64;

  always_comb begin
    size    = mode_size(mode_i);
    span    = {2'b00, offset_i} + {1'b0, size};
    split_o = SPLIT_MISALIGNED && (span > 4'd4);

    // 8-bit mask so bytes past the word boundary land in beat1's enables.
    mask  = ((8'd1 << size) - 8'd1) << offset_i;
    be0_o = mask[3:0];
    be1_o = mask[7:4];

    w64      = {32'b0, wdata_i} << {offset_i, 3'b000};
    wdata0_o = w64[31:0];
    wdata1_o = w64[63:32];

    r64 = {hi_i, lo_i} >> {offset_i, 3'b000};
    unique case (size)
      3'd1:    load_data_o = {{24{r64[7] & ~unsigned_i}}, r64[7:0]};
      3'd2:    load_data_o = {{16{r64[15] & ~unsigned_i}}, r64[15:0]};
      default: load_data_o = r64[31:0];
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// MEM-stage load/store unit. Turns one pipeline memory request into one or two
// aligned word beats on the data-memory bus and stalls the pipeline until done.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_*               : pipeline request (held stable while stall=1)
//   stall               : hold IF..MEM stages
//   done / rdata_valid  : one-cycle completion pulses (rdata_valid for loads only)
//   rdata               : extended load result, held until the next load completes
//   bus                 : valid/ready data-memory bus (master side)
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter bit          SPLIT_MISALIGNED = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_read,
  input  logic                         req_write,
  input  logic [MEMORY_MODE_WIDTH-1:0] req_mode,
  input  logic                         req_unsigned,
  input  logic [ADDR_WIDTH-1:0]        req_addr,
  input  logic [31:0]                  req_wdata,
  output logic                         stall,
  output logic                         done,
  output logic [31:0]                  rdata,
  output logic                         rdata_valid,
  dmem_lsu_if.master                   bus
);

  lsu_state_t state_q, state_d;

  logic                         write_q;
  logic [MEMORY_MODE_WIDTH-1:0] mode_q;
  logic                         unsigned_q;
  logic [ADDR_WIDTH-1:0]        addr_q;
  logic [31:0]                  wdata_q;
  logic [31:0]                  lo_q, hi_q;
  logic [31:0]                  rdata_q;

  logic capture, lo_en, hi_en, rdata_en;

  logic                    split;
  logic [LSU_BE_WIDTH-1:0] be0, be1;
  logic [31:0]             wdata0, wdata1, load_data;
  logic [31:0]             lo_src, hi_src;
  logic [ADDR_WIDTH-1:0]   beat0_addr, beat1_addr;

  // Feed the arriving response straight into extraction so rdata can be
  // registered on the same edge that enters DONE.
  assign lo_src = (state_q == WAIT0) ? bus.bus_rsp_rdata : lo_q;
  assign hi_src = (state_q == WAIT1) ? bus.bus_rsp_rdata : hi_q;

  assign beat0_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign beat1_addr = beat0_addr + ADDR_WIDTH'(4);

  lsu_align #(
    .SPLIT_MISALIGNED(SPLIT_MISALIGNED)
  ) u_align (
    .offset_i   (addr_q[1:0]),
    .mode_i     (mode_q),
    .unsigned_i (unsigned_q),
    .wdata_i    (wdata_q),
    .lo_i       (lo_src),
    .hi_i       (hi_src),
    .split_o    (split),
    .be0_o      (be0),
    .be1_o      (be1),
    .wdata0_o   (wdata0),
    .wdata1_o   (wdata1),
    .load_data_o(load_data)
  );

  always_comb begin
    state_d           = state_q;
    stall             = 1'b0;
    done              = 1'b0;
    rdata_valid       = 1'b0;
    capture           = 1'b0;
    lo_en             = 1'b0;
    hi_en             = 1'b0;
    rdata_en          = 1'b0;
    bus.bus_req_valid = 1'b0;
    bus.bus_req_we    = 1'b0;
    bus.bus_req_addr  = '0;
    bus.bus_req_wdata = '0;
    bus.bus_req_be    = '0;

    unique case (state_q)
      IDLE: begin
        if (req_read || req_write) begin
          stall   = 1'b1;
          capture = 1'b1;
          state_d = ISSUE0;
        end
      end
      ISSUE0: begin
        stall             = 1'b1;
        bus.bus_req_valid = 1'b1;
        bus.bus_req_we    = write_q;
        bus.bus_req_addr  = beat0_addr;
        bus.bus_req_wdata = wdata0;
        bus.bus_req_be    = be0;
        if (bus.bus_req_ready) state_d = WAIT0;
      end
      WAIT0: begin
        stall = 1'b1;
        if (bus.bus_rsp_valid) begin
          lo_en = 1'b1;
          if (split) begin
            state_d = ISSUE1;
          end else begin
            rdata_en = ~write_q;
            state_d  = DONE;
          end
        end
      end
      ISSUE1: begin
        stall             = 1'b1;
        bus.bus_req_valid = 1'b1;
        bus.bus_req_we    = write_q;
        bus.bus_req_addr  = beat1_addr;
        bus.bus_req_wdata = wdata1;
        bus.bus_req_be    = be1;
        if (bus.bus_req_ready) state_d = WAIT1;
      end
      WAIT1: begin
        stall = 1'b1;
        if (bus.bus_rsp_valid) begin
          hi_en    = 1'b1;
          rdata_en = ~write_q;
          state_d  = DONE;
        end
      end
      DONE: begin
        done        = 1'b1;
        rdata_valid = ~write_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rdata = rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      mode_q     <= '0;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        // A simultaneous read and write is treated as a write.
        write_q    <= req_write;
        mode_q     <= req_mode;
        unsigned_q <= req_unsigned;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        hi_q       <= '0;
      end
      if (lo_en)    lo_q    <= bus.bus_rsp_rdata;
      if (hi_en)    hi_q    <= bus.bus_rsp_rdata;
      if (rdata_en) rdata_q <= load_data;
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
module tb_dmem_lsu;
  import dmem_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_read = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_mode = 2'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        stall, done, rdata_valid;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  dmem_lsu_if #(.ADDR_WIDTH(32)) bus ();

  dmem_lsu #(
    .ADDR_WIDTH      (32),
    .SPLIT_MISALIGNED(1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_read    (req_read),
    .req_write   (req_write),
    .req_mode    (req_mode),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .stall       (stall),
    .done        (done),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .bus         (bus)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } beat_t;

  typedef struct {
    logic        is_load;
    logic [31:0] rdata;
    int          lat;
    int          start;
  } cpl_t;

  beat_t       exp_beats[$];
  cpl_t        exp_cpls[$];
  logic [31:0] rsp_words[$];

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          ready_hold = 0;
  int          rsp_extra = 0;
  logic [31:0] last_load = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_beat(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input logic [31:0] rsp);
    beat_t b;
    b.we = we; b.addr = addr; b.wdata = wdata; b.be = be;
    exp_beats.push_back(b);
    rsp_words.push_back(rsp);
  endtask

  // Memory responder: optional ready-low cycles, response rsp_extra cycles late.
  initial begin
    int pend;
    pend = 0;
    bus.bus_req_ready = 1'b1;
    bus.bus_rsp_valid = 1'b0;
    bus.bus_rsp_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.bus_rsp_valid = 1'b0;
      bus.bus_rsp_rdata = '0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.bus_rsp_valid = 1'b1;
          bus.bus_rsp_rdata = (rsp_words.size() > 0) ? rsp_words.pop_front() : 32'h0;
        end
      end
      if (bus.bus_req_valid && ready_hold > 0) begin
        bus.bus_req_ready = 1'b0;
        ready_hold--;
      end else begin
        bus.bus_req_ready = 1'b1;
      end
      if (bus.bus_req_valid && bus.bus_req_ready) pend = 1 + rsp_extra;
    end
  end

  // Monitor: compares bus beats and completions against the scoreboard queues.
  initial begin
    int    stall_run;
    beat_t b;
    cpl_t  c;
    stall_run = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_run = 0;
        continue;
      end
      if (stall) stall_run++;
      if (bus.bus_req_valid && !bus.bus_req_ready && exp_beats.size() > 0) begin
        b = exp_beats[0];
        check("hold_addr", bus.bus_req_addr, b.addr);
        check("hold_be", {28'b0, bus.bus_req_be}, {28'b0, b.be});
        if (b.we) check("hold_wdata", bus.bus_req_wdata, b.wdata);
      end
      if (bus.bus_req_valid && bus.bus_req_ready) begin
        if (exp_beats.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got addr 0x%08h, expected no beat", bus.bus_req_addr);
        end else begin
          b = exp_beats.pop_front();
          check("beat_we", {31'b0, bus.bus_req_we}, {31'b0, b.we});
          check("beat_addr", bus.bus_req_addr, b.addr);
          check("beat_be", {28'b0, bus.bus_req_be}, {28'b0, b.be});
          if (b.we) check("beat_wdata", bus.bus_req_wdata, b.wdata);
        end
      end
      if (done) begin
        if (exp_cpls.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1, expected 0");
        end else begin
          c = exp_cpls.pop_front();
          check("rdata_valid", {31'b0, rdata_valid}, {31'b0, c.is_load});
          check("rdata", rdata, c.rdata);
          check("latency", cyc - c.start, c.lat);
          check("stall_cycles", stall_run, c.lat);
        end
        stall_run = 0;
      end else if (rdata_valid) begin
        n_checks++;
        n_fail++;
        $display("FAIL stray_rdata_valid: got 1, expected 0");
      end
    end
  end

  task automatic access(input logic rd, input logic wr, input logic [1:0] mode, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int lat,
                        input logic [31:0] exp_rdata);
    cpl_t c;
    bit   seen;
    @(posedge clk);
    #1;
    req_read = rd; req_write = wr; req_mode = mode; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    c.is_load = !wr;
    if (!wr) last_load = exp_rdata;
    c.rdata = last_load;
    c.lat = lat;
    c.start = cyc;
    exp_cpls.push_back(c);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: got no done at 0x%08h, expected done", addr);
    end
    req_read = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, {31'b0, stall}, 32'h0);
    check({tag, "_done"}, {31'b0, done}, 32'h0);
    check({tag, "_rdata"}, rdata, 32'h0);
    check({tag, "_rdata_valid"}, {31'b0, rdata_valid}, 32'h0);
    check({tag, "_valid"}, {31'b0, bus.bus_req_valid}, 32'h0);
    check({tag, "_we"}, {31'b0, bus.bus_req_we}, 32'h0);
    check({tag, "_addr"}, bus.bus_req_addr, 32'h0);
    check({tag, "_wdata"}, bus.bus_req_wdata, 32'h0);
    check({tag, "_be"}, {28'b0, bus.bus_req_be}, 32'h0);
  endtask

  initial begin
    #12;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Aligned loads
    push_beat(1'b0, 32'h100, 32'h0, 4'b1111, 32'hDEADBEEF);
    access(1'b1, 1'b0, WORD_MEMORY_MODE, 1'b0, 32'h100, 32'h0, 3, 32'hDEADBEEF);
    push_beat(1'b0, 32'h200, 32'h0, 4'b1000, 32'h80FFFFFF);
    access(1'b1, 1'b0, BYTE_MEMORY_MODE, 1'b0, 32'h203, 32'h0, 3, 32'hFFFFFF80);
    push_beat(1'b0, 32'h200, 32'h0, 4'b1000, 32'h80FFFFFF);
    access(1'b1, 1'b0, BYTE_MEMORY_MODE, 1'b1, 32'h203, 32'h0, 3, 32'h00000080);

    // Split store, rdata must keep the last load value
    push_beat(1'b1, 32'h300, 32'h22334400, 4'b1110, 32'h0);
    push_beat(1'b1, 32'h304, 32'h00000011, 4'b0001, 32'h0);
    access(1'b0, 1'b1, WORD_MEMORY_MODE, 1'b0, 32'h301, 32'h11223344, 5, 32'h0);

    // Split halfword load wrapping past the top of the address space
    push_beat(1'b0, 32'hFFFFFFFC, 32'h0, 4'b1000, 32'hAB000000);
    push_beat(1'b0, 32'h00000000, 32'h0, 4'b0001, 32'h000000CD);
    access(1'b1, 1'b0, HALFWORD_MEMORY_MODE, 1'b0, 32'hFFFFFFFF, 32'h0, 5, 32'hFFFFCDAB);

    // Halfword store with ready held low for 3 cycles
    ready_hold = 3;
    push_beat(1'b1, 32'h10, 32'hCAFEBEEF, 4'b0011, 32'h0);
    access(1'b0, 1'b1, HALFWORD_MEMORY_MODE, 1'b0, 32'h10, 32'hCAFEBEEF, 6, 32'h0);

    push_beat(1'b0, 32'h100, 32'h0, 4'b1100, 32'h80012345);
    access(1'b1, 1'b0, HALFWORD_MEMORY_MODE, 1'b1, 32'h102, 32'h0, 3, 32'h00008001);
    push_beat(1'b1, 32'h4, 32'hAA000000, 4'b1000, 32'h0);
    access(1'b0, 1'b1, BYTE_MEMORY_MODE, 1'b0, 32'h7, 32'h000000AA, 3, 32'h0);
    // Unused mode encoding acts as word
    push_beat(1'b0, 32'h20, 32'h0, 4'b1111, 32'h01234567);
    access(1'b1, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 3, 32'h01234567);
    // Read and write together: write wins
    push_beat(1'b1, 32'h40, 32'h12345678, 4'b1111, 32'h0);
    access(1'b1, 1'b1, WORD_MEMORY_MODE, 1'b0, 32'h40, 32'h12345678, 3, 32'h0);
    // One extra response cycle
    rsp_extra = 1;
    push_beat(1'b0, 32'h104, 32'h0, 4'b1111, 32'h0BADF00D);
    access(1'b1, 1'b0, WORD_MEMORY_MODE, 1'b0, 32'h104, 32'h0, 4, 32'h0BADF00D);
    rsp_extra = 0;
    // Misaligned word load split over two beats
    push_beat(1'b0, 32'h104, 32'h0, 4'b1100, 32'hAABBCCDD);
    push_beat(1'b0, 32'h108, 32'h0, 4'b0011, 32'h11223344);
    access(1'b1, 1'b0, WORD_MEMORY_MODE, 1'b0, 32'h106, 32'h0, 5, 32'h3344AABB);

    // Reset during WAIT0 with a late response arriving after release
    rsp_extra = 3;
    push_beat(1'b0, 32'h400, 32'h0, 4'b1111, 32'h55AA55AA);
    @(posedge clk);
    #1;
    req_read = 1'b1; req_write = 1'b0; req_mode = WORD_MEMORY_MODE; req_addr = 32'h400;
    @(posedge clk);
    @(posedge clk);
    #1;
    req_read = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_extra = 0;
    last_load = '0;
    repeat (8) @(posedge clk);
    #1;
    check("post_abort_rdata", rdata, 32'h0);
    check("post_abort_beats", exp_beats.size(), 0);

    push_beat(1'b0, 32'h500, 32'h0, 4'b1111, 32'h600D600D);
    access(1'b1, 1'b0, WORD_MEMORY_MODE, 1'b0, 32'h500, 32'h0, 3, 32'h600D600D);
    repeat (3) @(posedge clk);
    check("cpls_drained", exp_cpls.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, expected finish");
    $fatal(1);
  end

endmodule
